// File: rtl/joy_db15_reader.sv
// Serial front end for the DB15 UserIO joystick adapter.
// Drives the adapter's load and shift-clock lines and de-serialises two player
// words. Both words update together once per scan frame, with a joy_valid pulse.
module joy_db15_reader #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned NBITS     = 12,
    parameter int unsigned GAP_TICKS = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        joy_valid
);

    localparam int unsigned DW = 10;
    localparam int unsigned GW = 16;
    localparam int unsigned SW = 2 * NBITS;
    localparam int unsigned KW = $clog2(SW);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_DONE
    } state_t;

    logic [1:0]    sync_q;
    logic [DW-1:0] div_q,   div_d;
    state_t        state_q, state_d;
    logic [GW-1:0] gap_q,   gap_d;
    logic [KW-1:0] k_q,     k_d;
    logic [SW-1:0] shift_q, shift_d;
    logic [15:0]   joy1_q,  joy1_d;
    logic [15:0]   joy2_q,  joy2_d;
    logic          joy_clk_q,  joy_clk_d;
    logic          joy_load_q, joy_load_d;
    logic          valid_q,    valid_d;
    logic          tick_c;

    assign tick_c = enable && (div_q == DW'(CLK_DIV - 1));

    // Two-flop synchroniser for the asynchronous serial data line.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], JOY_DATA};
        end
    end

    // Tick divider; parked at 0 while disabled and during the DONE cycle so
    // the next gap starts on a fresh tick boundary.
    always_comb begin
        div_d = div_q;
        if (!enable || (state_q == ST_DONE) || tick_c) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    // Next-state and registered-output decode for the scan sequencer.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        k_d     = k_q;
        shift_d = shift_q;
        joy1_d  = joy1_q;
        joy2_d  = joy2_q;

        if (!enable) begin
            state_d = ST_IDLE;
            gap_d   = '0;
            k_d     = '0;
            shift_d = '0;
            joy1_d  = '0;
            joy2_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick_c) begin
                        if (gap_q == GW'(GAP_TICKS - 1)) begin
                            gap_d   = '0;
                            state_d = ST_LOAD;
                        end else begin
                            gap_d = gap_q + GW'(1);
                        end
                    end
                end
                ST_LOAD: begin
                    if (tick_c) begin
                        k_d     = '0;
                        state_d = ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (tick_c) begin
                        shift_d[k_q] = ~sync_q[1];
                        state_d      = ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (tick_c) begin
                        if (k_q == KW'(SW - 1)) begin
                            joy1_d  = 16'(shift_q[NBITS-1:0]);
                            joy2_d  = 16'(shift_q[SW-1:NBITS]);
                            state_d = ST_DONE;
                        end else begin
                            k_d     = k_q + KW'(1);
                            state_d = ST_SHIFT_LO;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Pin levels follow the state being entered so they flip on the same edge.
        joy_clk_d  = (state_d != ST_SHIFT_LO);
        joy_load_d = (state_d != ST_LOAD);
        valid_d    = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_q      <= '0;
            state_q    <= ST_IDLE;
            gap_q      <= '0;
            k_q        <= '0;
            shift_q    <= '0;
            joy1_q     <= '0;
            joy2_q     <= '0;
            joy_clk_q  <= 1'b1;
            joy_load_q <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            div_q      <= div_d;
            state_q    <= state_d;
            gap_q      <= gap_d;
            k_q        <= k_d;
            shift_q    <= shift_d;
            joy1_q     <= joy1_d;
            joy2_q     <= joy2_d;
            joy_clk_q  <= joy_clk_d;
            joy_load_q <= joy_load_d;
            valid_q    <= valid_d;
        end
    end

    assign JOY_CLK   = joy_clk_q;
    assign JOY_LOAD  = joy_load_q;
    assign joystick1 = joy1_q;
    assign joystick2 = joy2_q;
    assign joy_valid = valid_q;

endmodule

// File: doc/joy_db15_reader.md
Name: joy_db15_reader

Overview:
- Serial front end for the DB15 UserIO joystick adapter. It drives the adapter's parallel-load and shift-clock lines and samples the serial data line.
- Delivers two de-serialised, active-high button words in the LS FEDCBA UDLR layout. These feed the joystick mux in the top-level core.
- Sits directly upstream of the joystick_0/joystick_1 selection logic.
- Runs continuously while enabled and updates both words atomically once per scan frame.

Parameters:
- CLK_DIV, 4: clk_sys cycles per tick. Legal range 4..1023.
- NBITS, 12: bits per player. Legal range 1..16.
- GAP_TICKS, 16: idle ticks between frames. Legal range 1..65535.

Ports:
- clk_sys input 1: core clock, 40-50 MHz.
- reset_n input 1: asynchronous, active-low reset.
- enable input 1: scanning enabled; tied to the UserIO DB15 mode select.
- JOY_DATA input 1: serial data from the adapter. Asynchronous; a low level means the button is pressed.
- JOY_CLK output 1: shift clock to the adapter. Idles high.
- JOY_LOAD output 1: parallel load, active low. Idles high.
- joystick1 output 16: player 1 buttons, active-high. Bits above NBITS-1 are 0.
- joystick2 output 16: player 2 buttons, same layout as joystick1.
- joy_valid output 1: one-clk_sys pulse when joystick1/joystick2 update.

Behaviour:
- Reset (reset_n low, async) sets the following:
  - JOY_CLK=1, JOY_LOAD=1, joystick1=0, joystick2=0, joy_valid=0.
  - Divider=0, state=IDLE, bit counter=0, shift register=0.
- JOY_DATA passes through a 2-flop synchroniser. The sampled value is always the synchroniser output.
- Tick generation:
  - The divider counts 0..CLK_DIV-1 while enable=1.
  - A tick is asserted in the clk_sys cycle where divider==CLK_DIV-1.
  - The divider is held at 0 while enable=0.
- All state transitions happen only on ticks.
- IDLE:
  - JOY_CLK=1, JOY_LOAD=1.
  - Counts GAP_TICKS ticks, then goes to LOAD.
- LOAD:
  - JOY_LOAD=0 for exactly 1 tick, JOY_CLK=1.
  - Then goes to SHIFT_LO with bit index 0.
- SHIFT_LO:
  - JOY_CLK=0 for 1 tick.
  - On the tick that ends this state, the synchronised JOY_DATA is sampled, inverted, and stored at shift position k (0..2*NBITS-1).
  - Then goes to SHIFT_HI.
- SHIFT_HI:
  - JOY_CLK=1 for 1 tick. The rising edge at entry advances the adapter's shift register.
  - If k==2*NBITS-1, goes to DONE; otherwise k increments and the state returns to SHIFT_LO.
- DONE (one clk_sys cycle, no tick needed):
  - joystick1[i] = sample[i] for i<NBITS.
  - joystick2[i] = sample[NBITS+i].
  - joy_valid=1 for this single cycle.
  - Then goes to IDLE.
- Frame period is (GAP_TICKS + 1 + 4*NBITS)*CLK_DIV clk_sys cycles, plus 1 cycle for DONE.
- Outputs JOY_CLK and JOY_LOAD are registered; no combinational glitches are allowed.
- Outputs hold their last values between DONE pulses. A partial frame never reaches the outputs.
- enable dropping mid-frame:
  - Abort at the next clk_sys edge (not on a tick) and go to IDLE.
  - JOY_CLK=1, JOY_LOAD=1, joystick1=joystick2=0, joy_valid=0.
  - Bit counter and shift register are cleared.
- enable rising: the first frame starts with a full IDLE gap.
- Reset asserted mid-frame: immediate return to reset values, no joy_valid pulse.

Test Plan:
- Reset, then enable=1 with default parameters:
  - The first JOY_LOAD low pulse begins (16 ticks)*4 = 64 cycles after enable.
  - The pulse is 4 cycles wide.
  - 24 JOY_CLK low pulses follow, each 4 cycles wide.
  - joy_valid pulses once; the next one comes 261 cycles later.
- Adapter model shifts out P1 = 12'hFFE and P2 = 12'h7FF, active-low (bit0 first):
  - joystick1 = 16'h0001 (right pressed).
  - joystick2 = 16'h0800 (bit 11 = L pressed).
- Adapter value changes between frames: outputs change only in the cycle of joy_valid; intermediate values are never visible.
- Drop enable during the 10th SHIFT_LO:
  - Next cycle JOY_CLK=1 and outputs are 0.
  - No joy_valid pulse occurs.
  - On re-enable, the 64-cycle gap precedes the LOAD pulse.
- Assert reset_n low asynchronously mid-SHIFT_HI: outputs reach reset values without a clock edge.
- NBITS=16, CLK_DIV=5, JOY_DATA held low: joystick1 = joystick2 = 16'hFFFF after the first frame.
